timer_req_sequencer: RTL and testbench

//  Shares one serial-start timer FSM (1101 start pattern, 4-bit delay, counts (delay+1)*1000 cycles, done/ack) among
//  N_REQ requesters. Round-robin grants one requester and serialises the start pattern plus that requester's delay onto t_data.

---
 rtl/timer_req_sequencer_pkg.sv | 17 +
 rtl/timer_req_sequencer_rr_arbiter.sv | 40 ++++
 rtl/timer_req_sequencer.sv | 121 ++++++++++++
 tb/tb_timer_req_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_req_sequencer_pkg.sv
// Shared constants and FSM state encoding for the timer request sequencer.
package timer_req_sequencer_pkg;

    localparam logic [3:0] START_PAT    = 4'b1101;
    localparam int         DELAY_W      = 4;
    localparam int         CYC_PER_UNIT = 1000;
    localparam int         SEND_BITS    = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_ACK  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

endpackage

// File: rtl/timer_req_sequencer_rr_arbiter.sv
// Round-robin requester selection: combinational pick starting at the pointer,
// pointer moves past the served requester when advance is pulsed.
module timer_req_sequencer_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic [ID_W-1:0]  done_id,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_idx
);

    logic [ID_W-1:0] ptr;

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (done_id == ID_W'(N_REQ - 1)) ? '0 : done_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/timer_req_sequencer.sv
// Shares one serial-start timer among N_REQ requesters: grants round-robin,
// serialises 1101 + delay onto t_data, waits for t_done (or watchdog), acks and completes.
module timer_req_sequencer #(
    parameter int N_REQ       = 2,
    parameter int ID_W        = 1,
    parameter int TIMEOUT_CYC = 16100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] delay,
    output logic [N_REQ-1:0]   cpl,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               err,
    output logic               t_data,
    output logic               t_ack,
    input  logic               t_counting,
    input  logic               t_done
);

    import timer_req_sequencer_pkg::*;

    localparam int               WD_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_t               state;
    logic [SEND_BITS-1:0] shreg;
    logic [2:0]           bit_cnt;
    logic [WD_W-1:0]      wdog;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_idx;
    logic [DELAY_W-1:0]   grant_delay;
    logic                 unused_counting;

    assign unused_counting = t_counting;
    assign grant_delay     = delay[DELAY_W*int'(grant_idx) +: DELAY_W];

    timer_req_sequencer_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .advance     (state == S_ACK),
        .done_id     (grant_id),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // The first pattern bit is driven at the grant edge, so shreg holds the
    // remaining seven bits MSB-first and t_data is always one bit ahead of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            wdog     <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            cpl      <= '0;
            t_data   <= 1'b0;
            t_ack    <= 1'b0;
        end else begin
            cpl    <= '0;
            t_ack  <= 1'b0;
            t_data <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        grant_id <= grant_idx;
                        shreg    <= {START_PAT[2:0], grant_delay, 1'b0};
                        t_data   <= START_PAT[3];
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'(SEND_BITS - 1)) begin
                        wdog  <= '0;
                        state <= S_WAIT;
                    end else begin
                        t_data <= shreg[SEND_BITS-1];
                    end
                end
                // A real done beats a simultaneous watchdog expiry.
                S_WAIT: begin
                    if (t_done) begin
                        t_ack <= 1'b1;
                        cpl   <= ONE_HOT0 << grant_id;
                        state <= S_ACK;
                    end else if (wdog == WD_LAST) begin
                        err   <= 1'b1;
                        t_ack <= 1'b1;
                        cpl   <= ONE_HOT0 << grant_id;
                        state <= S_ACK;
                    end else if (wdog != '1) begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                S_ACK: begin
                    state <= S_GAP;
                end
                S_GAP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_req_sequencer.sv
// Self-checking bench: behavioural serial-start timer on t_*, cpl scoreboard,
// table of single jobs plus hand-written round-robin, reset-abort and watchdog sequences.
module tb_timer_req_sequencer;

    localparam int TO = 16100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = '0;
    logic [7:0] delay = '0;
    logic [1:0] cpl;
    logic       busy;
    logic [0:0] grant_id;
    logic       err;
    logic       t_data;
    logic       t_ack;
    logic       t_counting;
    logic       t_done;
    logic       model_done;
    logic       stub_mode = 1'b0;
    logic       stub_done = 1'b0;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [1:0] cplv;
        logic       errv;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [3:0] d0;
        logic [3:0] d1;
        int         exp_id;
        int         exp_count;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    assign t_done = stub_mode ? stub_done : model_done;

    timer_req_sequencer #(
        .N_REQ       (2),
        .ID_W        (1),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .delay      (delay),
        .cpl        (cpl),
        .busy       (busy),
        .grant_id   (grant_id),
        .err        (err),
        .t_data     (t_data),
        .t_ack      (t_ack),
        .t_counting (t_counting),
        .t_done     (t_done)
    );

    // Timer model: hunt for 1101, shift in 4 delay bits, count (d+1)*1000, hold done until ack.
    typedef enum logic [1:0] {M_SEARCH, M_LOAD, M_COUNT, M_DONE} mstate_t;
    mstate_t    m_state;
    logic [3:0] m_shift;
    logic [3:0] m_dly;
    logic [1:0] m_bits;
    int         m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_state    <= M_SEARCH;
            m_shift    <= '0;
            m_dly      <= '0;
            m_bits     <= '0;
            m_cnt      <= 0;
            model_done <= 1'b0;
            t_counting <= 1'b0;
        end else begin
            case (m_state)
                M_SEARCH: begin
                    m_shift <= {m_shift[2:0], t_data};
                    if ({m_shift[2:0], t_data} == 4'b1101) begin
                        m_state <= M_LOAD;
                        m_bits  <= '0;
                    end
                end
                M_LOAD: begin
                    m_dly  <= {m_dly[2:0], t_data};
                    m_bits <= m_bits + 2'd1;
                    if (m_bits == 2'd3) begin
                        m_cnt      <= (int'({m_dly[2:0], t_data}) + 1) * 1000;
                        t_counting <= 1'b1;
                        m_state    <= M_COUNT;
                    end
                end
                M_COUNT: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        t_counting <= 1'b0;
                        model_done <= 1'b1;
                        m_state    <= M_DONE;
                    end
                end
                default: begin
                    if (t_ack) begin
                        model_done <= 1'b0;
                        m_shift    <= '0;
                        m_state    <= M_SEARCH;
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : cpl_monitor
        exp_t e;
        if (cpl != '0) begin
            if (sb_q.size() == 0) begin
                checkOutput("cpl_unexpected", 32'(cpl), 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("cpl_vector", 32'(cpl), 32'(e.cplv));
                checkOutput("cpl_err", 32'(err), 32'(e.errv));
            end
        end
    end

    task automatic pushExp(input logic [1:0] cplv, input logic errv);
        exp_t e;
        e.cplv = cplv;
        e.errv = errv;
        sb_q.push_back(e);
    endtask

    task automatic resetDut();
        checkOutput("sb_drained", sb_q.size(), 0);
        sb_q.delete();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_cpl", 32'(cpl), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_t_data", 32'(t_data), 0);
        checkOutput("rst_t_ack", 32'(t_ack), 0);
        checkOutput("rst_grant_id", 32'(grant_id), 0);
        reset = 1'b0;
    endtask

    task automatic waitBusy(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("busy_rise_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        bit         ok;
        bit         seen;
        int         counted;
        logic [7:0] pat;
        pat = {4'b1101, (v.exp_id == 0) ? v.d0 : v.d1};
        pushExp(2'b01 << v.exp_id, 1'b0);
        delay = {v.d1, v.d0};
        req   = v.req;
        waitBusy(ok);
        if (ok) begin
            checkOutput("grant_id", 32'(grant_id), v.exp_id);
            for (int b = 0; b < 8; b++) begin
                if (b > 0) @(negedge clk);
                checkOutput("t_data_bit", 32'(t_data), 32'(pat[7-b]));
            end
            @(negedge clk);
            checkOutput("t_data_wait", 32'(t_data), 0);
            counted = 0;
            seen    = 1'b0;
            for (int n = 0; n < 20000; n++) begin
                if (t_counting) counted++;
                if (cpl != '0) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            checkOutput("cpl_seen", 32'(seen), 1);
            checkOutput("t_counting_len", counted, v.exp_count);
            checkOutput("t_ack_with_cpl", 32'(t_ack), 1);
            req = '0;
            @(negedge clk);
            checkOutput("busy_in_gap", 32'(busy), 1);
            checkOutput("t_ack_one_cycle", 32'(t_ack), 0);
            @(negedge clk);
            checkOutput("busy_after_gap", 32'(busy), 0);
            checkOutput("err_clear", 32'(err), 0);
        end
    endtask

    initial begin
        bit   ok;
        bit   seen;
        int   n;
        vec_t v;

        vecs[0] = '{req: 2'b01, d0: 4'h0, d1: 4'h0, exp_id: 0, exp_count: 1000};
        vecs[1] = '{req: 2'b01, d0: 4'hF, d1: 4'h0, exp_id: 0, exp_count: 16000};
        vecs[2] = '{req: 2'b10, d0: 4'h0, d1: 4'h3, exp_id: 1, exp_count: 4000};
        vecs[3] = '{req: 2'b01, d0: 4'h5, d1: 4'h9, exp_id: 0, exp_count: 6000};

        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        $display("[TB] round-robin with both requesters active");
        req   = 2'b11;
        delay = 8'h00;
        resetDut();
        for (int k = 0; k < 4; k++) pushExp((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (cpl != '0) begin
                    seen = 1'b1;
                    break;
                end
            end
            checkOutput("rr_cpl_seen", 32'(seen), 1);
            checkOutput("rr_grant_order", 32'(grant_id), k % 2);
            if (k == 3) begin
                req = '0;
            end else begin
                req[k % 2] = 1'b0;
                repeat (2) @(negedge clk);
                req[k % 2] = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
        checkOutput("rr_idle", 32'(busy), 0);

        $display("[TB] reset during SEND bit 3");
        resetDut();
        delay = 8'h00;
        req   = 2'b01;
        waitBusy(ok);
        repeat (2) @(negedge clk);
        checkOutput("abort_bit3", 32'(t_data), 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_t_data", 32'(t_data), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_cpl", 32'(cpl), 0);
        reset = 1'b0;
        v = '{req: 2'b01, d0: 4'h0, d1: 4'h0, exp_id: 0, exp_count: 1000};
        applyStimulus(v);

        $display("[TB] watchdog timeout with stub timer");
        stub_mode = 1'b1;
        stub_done = 1'b0;
        resetDut();
        pushExp(2'b01, 1'b1);
        req = 2'b01;
        waitBusy(ok);
        n    = 1;
        seen = 1'b0;
        for (int i = 0; i < TO + 50; i++) begin
            @(negedge clk);
            n++;
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("timeout_seen", 32'(seen), 1);
        checkOutput("timeout_cycle", n, TO + 9);
        checkOutput("timeout_ack", 32'(t_ack), 1);
        req = '0;
        repeat (5) @(negedge clk);
        checkOutput("err_sticky", 32'(err), 1);
        checkOutput("idle_after_timeout", 32'(busy), 0);

        $display("[TB] done and watchdog expiry in the same cycle");
        resetDut();
        pushExp(2'b01, 1'b0);
        req = 2'b01;
        waitBusy(ok);
        n    = 1;
        seen = 1'b0;
        for (int i = 0; i < TO + 50; i++) begin
            if (n == 8 + TO) stub_done = 1'b1;
            @(negedge clk);
            n++;
            if (cpl != '0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("tie_cpl_seen", 32'(seen), 1);
        checkOutput("tie_cycle", n, TO + 9);
        checkOutput("tie_err", 32'(err), 0);
        stub_done = 1'b0;
        req       = '0;
        repeat (3) @(negedge clk);
        stub_mode = 1'b0;
        checkOutput("sb_final_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
